// File: rtl/byte_assembler_pkg.sv
// Shared types and constants for the serial-to-parallel byte assembler.
package byte_assembler_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } asm_state_t;

    localparam int BYTE_W = 8;
    // Bit counter only needs to count 0..BYTE_W-1; the last bit wraps it to 0.
    localparam int BITCNT_W = $clog2(BYTE_W);

endpackage

// File: rtl/byte_assembler_rise_detect.sv
// Registered rising-edge detector. The previous-level register resets to
// RESET_VAL so that a level already high at reset release can be masked.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    // Remember the level seen on the previous clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/byte_assembler.sv
// Assembles MSB-first serial bits (one per write strobe rising edge) into
// bytes and presents each byte on a valid/ack handshake.
//
// Handshake: data_ready_out is the valid. Once high it stays high, with
// data_out stable, until ack_in is sampled high on a clock edge; the byte is
// consumed on that edge and data_ready_out is low from the next cycle on.
// ack_in is ignored while data_ready_out is low.
module byte_assembler
    import byte_assembler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              ack_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              data_ready_out,
    output logic              busy_out,
    output logic              overrun_out,
    output logic              frame_error_out,
    output logic              state_dbg_out
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
    // Idle count at which a partial byte is abandoned; reaching it on a
    // no-edge cycle means TIMEOUT_CYCLES idle cycles have elapsed.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(BYTE_W - 1);

    asm_state_t            state_q, state_d;
    logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic [BYTE_W-1:0]     data_q, data_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  ovr_q, ovr_d;
    logic                  fe_q, fe_d;
    logic                  wr_edge;

    // Strobe reset value of 1 masks a strobe held high across reset release.
    rise_detect #(
        .RESET_VAL(1'b1)
    ) u_rise_detect (
        .clk_i  (clock),
        .rst_i  (reset),
        .sig_i  (write_in),
        .rise_o (wr_edge)
    );

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= COLLECT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            idle_q    <= '0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            idle_q    <= idle_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
        end
    end

    // Next-state: shift in bits, time out stale partial bytes, hold for ack.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        idle_d    = idle_q;
        ovr_d     = 1'b0;
        fe_d      = 1'b0;

        case (state_q)
            COLLECT: begin
                if (wr_edge) begin
                    shift_d = {shift_q[BYTE_W-2:0], data_in};
                    idle_d  = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d    = {shift_q[BYTE_W-2:0], data_in};
                        bit_cnt_d = '0;
                        state_d   = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                    end
                end else if (bit_cnt_q != '0) begin
                    if (idle_q == IDLE_LAST) begin
                        // Abandon the partial byte; data_out keeps the last byte.
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        idle_d    = '0;
                        fe_d      = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            HOLD: begin
                // A bit arriving while the byte is unconsumed is dropped,
                // even on the ack cycle itself.
                if (wr_edge) begin
                    ovr_d = 1'b1;
                end
                if (ack_in) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    assign data_out        = data_q;
    assign data_ready_out  = (state_q == HOLD);
    assign busy_out        = (state_q == HOLD) | (bit_cnt_q != '0);
    assign overrun_out     = ovr_q;
    assign frame_error_out = fe_q;
    assign state_dbg_out   = state_q;

endmodule
